// File: rtl/i2c_sys_pkg.sv
// Shared definitions for the I2C burst controller: core register map, CR/SR bits,
// FSM/phase encodings, error codes and the Wishbone request bundle.
package i2c_sys_pkg;
  localparam logic [2:0] REG_PRER_LO = 3'd0;
  localparam logic [2:0] REG_PRER_HI = 3'd1;
  localparam logic [2:0] REG_CTR     = 3'd2;
  localparam logic [2:0] REG_TXR     = 3'd3;  // RXR on read
  localparam logic [2:0] REG_CR      = 3'd4;  // SR on read

  localparam logic [7:0] CTR_EN  = 8'h80;
  localparam logic [7:0] CR_STA  = 8'h80;
  localparam logic [7:0] CR_STO  = 8'h40;
  localparam logic [7:0] CR_RD   = 8'h20;
  localparam logic [7:0] CR_WR   = 8'h10;
  localparam logic [7:0] CR_NACK = 8'h08;

  localparam int SR_RXACK = 7;
  localparam int SR_AL    = 5;
  localparam int SR_TIP   = 1;

  typedef enum logic [1:0] {ERR_OK, ERR_NACK, ERR_AL, ERR_TMO} err_t;

  typedef enum logic [3:0] {
    IDLE, INIT_LO, INIT_HI, INIT_CTR, LD_TXR, WR_CR, POLL_SR, RD_RXR, STOP, FIN
  } state_t;

  typedef enum logic [1:0] {PH_SLA_W, PH_ADDR, PH_SLA_R, PH_DATA} phase_t;

  typedef struct packed {
    logic       we;
    logic [2:0] addr;
    logic [7:0] data;
  } wb_req_t;
endpackage

// File: rtl/i2c_wb_xfer.sv
// Single Wishbone read/write: registered bus signals held until ack or timeout,
// one-cycle done pulse with ok/tmo status and captured read data.
module i2c_wb_xfer
  import i2c_sys_pkg::*;
#(
  parameter int TMO_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  wb_req_t    cmd,
  output logic       done,
  output logic       ok,
  output logic       tmo,
  output logic [7:0] rdata,
  output logic [2:0] wb_addr,
  output logic [7:0] wb_wr_data,
  input  logic [7:0] wb_rd_data,
  output logic       wb_we,
  output logic       wb_stb,
  output logic       wb_cyc,
  input  logic       wb_ack
);
  localparam int CW = $clog2(TMO_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done <= 1'b0; ok <= 1'b0; tmo <= 1'b0; rdata <= '0; cnt <= '0;
      wb_addr <= '0; wb_wr_data <= '0; wb_we <= 1'b0; wb_stb <= 1'b0; wb_cyc <= 1'b0;
    end else begin
      done <= 1'b0;
      if (wb_cyc) begin
        if (wb_ack || cnt == CW'(TMO_CYCLES - 1)) begin
          wb_cyc <= 1'b0; wb_stb <= 1'b0; wb_we <= 1'b0;
          done   <= 1'b1;
          ok     <= wb_ack;
          tmo    <= !wb_ack;
          if (wb_ack) rdata <= wb_rd_data;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (req && !done) begin
        // the done cycle is always bus-idle, so back-to-back requests get a gap
        wb_cyc <= 1'b1; wb_stb <= 1'b1; wb_we <= cmd.we;
        wb_addr <= cmd.addr; wb_wr_data <= cmd.data;
        cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/i2c_burst_ctrl.sv
// Burst read/write sequencer driving an OpenCores-style I2C master over Wishbone.
// Init runs once after reset; each byte is TXR load, CR write, then SR polling.
module i2c_burst_ctrl
  import i2c_sys_pkg::*;
#(
  parameter logic [15:0] PRESCALE   = 16'h00C8,
  parameter int          MAX_BYTES  = 8,
  parameter int          ADDR_BYTES = 1,
  parameter int          TMO_CYCLES = 4096,
  localparam int         LW         = $clog2(MAX_BYTES) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   rnw,
  input  logic [6:0]             slave_addr,
  input  logic [15:0]            mem_addr,
  input  logic [LW-1:0]          len,
  input  logic [8*MAX_BYTES-1:0] wr_data,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             err,
  output logic                   rd_valid,
  output logic [7:0]             rd_data,
  output logic [2:0]             wb_addr,
  output logic [7:0]             wb_wr_data,
  input  logic [7:0]             wb_rd_data,
  output logic                   wb_we,
  output logic                   wb_stb,
  output logic                   wb_cyc,
  input  logic                   wb_ack,
  input  logic                   wb_inta
);
  localparam int TW = $clog2(TMO_CYCLES + 1);

  state_t                 state, nxt, adv;
  phase_t                 phase;
  err_t                   err_q;
  logic                   init_done, pend, stopping, rnw_q;
  logic [6:0]             sa_q;
  logic [15:0]            ma_q;
  logic [8*MAX_BYTES-1:0] wd_q;
  logic [LW-1:0]          cnt, len_eff;
  logic [1:0]             acnt;
  logic [TW-1:0]          tip_cnt;
  logic                   req, x_done, x_ok, x_tmo, last, wr_dir, tip_exp;
  logic [7:0]             sr, txr_val, cr_val;
  wb_req_t                cmd;
  logic                   unused_bits;

  assign unused_bits = ^{sr[6], sr[4:2], sr[0], wb_inta};
  assign last    = (cnt == LW'(1));
  assign wr_dir  = !(rnw_q && phase == PH_DATA);
  assign tip_exp = (tip_cnt >= TW'(TMO_CYCLES - 1));
  assign err     = err_q;

  always_comb begin
    len_eff = len;
    if (len == '0)                    len_eff = LW'(1);
    else if (len > LW'(MAX_BYTES))    len_eff = LW'(MAX_BYTES);
  end

  always_comb begin
    txr_val = wd_q[7:0];
    cr_val  = CR_WR;
    case (phase)
      PH_SLA_W: begin txr_val = {sa_q, 1'b0}; cr_val = CR_STA | CR_WR; end
      PH_ADDR:  txr_val = (acnt == 2'd2) ? ma_q[15:8] : ma_q[7:0];
      PH_SLA_R: begin txr_val = {sa_q, 1'b1}; cr_val = CR_STA | CR_WR; end
      default:  cr_val = rnw_q ? (last ? (CR_RD | CR_NACK | CR_STO) : CR_RD)
                               : (last ? (CR_STO | CR_WR) : CR_WR);
    endcase
  end

  // where a successfully completed byte phase goes next
  always_comb begin
    case (phase)
      PH_SLA_R: adv = WR_CR;
      PH_DATA:  adv = rnw_q ? RD_RXR : (last ? FIN : LD_TXR);
      default:  adv = LD_TXR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (start) nxt = init_done ? LD_TXR : INIT_LO;
      FIN:  nxt = IDLE;
      default:
        if (x_done) begin
          if (!x_ok) nxt = FIN;
          else case (state)
            INIT_LO:  nxt = INIT_HI;
            INIT_HI:  nxt = INIT_CTR;
            INIT_CTR: nxt = LD_TXR;
            LD_TXR:   nxt = WR_CR;
            WR_CR:    nxt = POLL_SR;
            STOP:     nxt = POLL_SR;
            RD_RXR:   nxt = last ? FIN : WR_CR;
            POLL_SR:
              if (sr[SR_AL])                   nxt = FIN;
              else if (sr[SR_TIP])             nxt = tip_exp ? FIN : POLL_SR;
              else if (stopping)               nxt = FIN;
              else if (wr_dir && sr[SR_RXACK]) nxt = STOP;
              else                             nxt = adv;
            default:  nxt = FIN;
          endcase
        end
    endcase
  end

  always_comb begin
    busy = !(state == IDLE || state == FIN);
    done = (state == FIN);
    req  = busy && !pend;
    cmd  = '{we: 1'b1, addr: REG_CR, data: 8'h00};
    case (state)
      INIT_LO:  cmd = '{we: 1'b1, addr: REG_PRER_LO, data: PRESCALE[7:0]};
      INIT_HI:  cmd = '{we: 1'b1, addr: REG_PRER_HI, data: PRESCALE[15:8]};
      INIT_CTR: cmd = '{we: 1'b1, addr: REG_CTR,     data: CTR_EN};
      LD_TXR:   cmd = '{we: 1'b1, addr: REG_TXR,     data: txr_val};
      WR_CR:    cmd = '{we: 1'b1, addr: REG_CR,      data: cr_val};
      STOP:     cmd = '{we: 1'b1, addr: REG_CR,      data: CR_STO};
      POLL_SR:  cmd = '{we: 1'b0, addr: REG_CR,      data: 8'h00};
      RD_RXR:   cmd = '{we: 1'b0, addr: REG_TXR,     data: 8'h00};
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_done <= 1'b0; pend <= 1'b0; stopping <= 1'b0; rnw_q <= 1'b0;
      phase <= PH_SLA_W; err_q <= ERR_OK; sa_q <= '0; ma_q <= '0; wd_q <= '0;
      cnt <= '0; acnt <= '0; tip_cnt <= '0; rd_valid <= 1'b0; rd_data <= '0;
    end else begin
      rd_valid <= 1'b0;
      if (x_done)   pend <= 1'b0;
      else if (req) pend <= 1'b1;
      if (state != POLL_SR) tip_cnt <= '0;
      else if (!tip_exp)    tip_cnt <= tip_cnt + 1'b1;
      if (state == IDLE && start) begin
        rnw_q <= rnw; sa_q <= slave_addr; ma_q <= mem_addr; wd_q <= wr_data;
        cnt <= len_eff; acnt <= 2'(ADDR_BYTES);
        phase <= PH_SLA_W; stopping <= 1'b0; err_q <= ERR_OK;
      end
      if (state == RD_RXR && wb_cyc && wb_ack) begin
        rd_valid <= 1'b1;
        rd_data  <= wb_rd_data;
      end
      if (x_done) begin
        if (x_tmo) err_q <= ERR_TMO;
        else case (state)
          INIT_CTR: init_done <= 1'b1;
          STOP:     stopping  <= 1'b1;
          RD_RXR:   if (!last) cnt <= cnt - 1'b1;
          POLL_SR:
            if (sr[SR_AL]) err_q <= ERR_AL;
            else if (sr[SR_TIP]) begin
              if (tip_exp) err_q <= ERR_TMO;
            end else if (!stopping) begin
              if (wr_dir && sr[SR_RXACK]) err_q <= ERR_NACK;
              else case (phase)
                PH_SLA_W: phase <= PH_ADDR;
                PH_ADDR:
                  if (acnt == 2'd1) phase <= rnw_q ? PH_SLA_R : PH_DATA;
                  else              acnt  <= acnt - 1'b1;
                PH_SLA_R: phase <= PH_DATA;
                default:
                  if (!rnw_q && !last) begin
                    cnt  <= cnt - 1'b1;
                    wd_q <= wd_q >> 8;
                  end
              endcase
            end
          default: ;
        endcase
      end
    end
  end

  i2c_wb_xfer #(.TMO_CYCLES(TMO_CYCLES)) u_xfer (
    .clk(clk), .rst(rst), .req(req), .cmd(cmd),
    .done(x_done), .ok(x_ok), .tmo(x_tmo), .rdata(sr),
    .wb_addr(wb_addr), .wb_wr_data(wb_wr_data), .wb_rd_data(wb_rd_data),
    .wb_we(wb_we), .wb_stb(wb_stb), .wb_cyc(wb_cyc), .wb_ack(wb_ack)
  );
endmodule

// File: tb/tb_i2c_burst_ctrl.sv
// Bench for i2c_burst_ctrl: behavioural I2C-core model on Wishbone, expected register
// write streams and read bytes built from the burst rules, randomized bursts.
module tb_i2c_burst_ctrl;
  localparam int MAXB = 8;
  localparam int LW   = $clog2(MAXB) + 1;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, rnw = 1'b0;
  logic [6:0]        slave_addr = '0;
  logic [15:0]       mem_addr = '0;
  logic [LW-1:0]     len = '0;
  logic [8*MAXB-1:0] wr_data = '0;
  logic              busy, done, rd_valid;
  logic [1:0]        err;
  logic [7:0]        rd_data, wb_wr_data;
  logic [2:0]        wb_addr;
  logic [7:0]        wb_rd_data = '0;
  logic              wb_we, wb_stb, wb_cyc;
  logic              wb_ack = 1'b0, wb_inta = 1'b0;

  int checks = 0, failures = 0;

  int           wlog[$], exp_w[$];
  byte unsigned rx_q[$], exp_rd[$], got_rd[$];
  int           cr_idx = 0, poll_n = 0, nack_at = -1, al_at = -1, tip_max = 2, tip_left = 0;
  bit           cur_nack = 1'b0, no_ack = 1'b0;

  i2c_burst_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .rnw(rnw), .slave_addr(slave_addr),
    .mem_addr(mem_addr), .len(len), .wr_data(wr_data), .busy(busy), .done(done),
    .err(err), .rd_valid(rd_valid), .rd_data(rd_data), .wb_addr(wb_addr),
    .wb_wr_data(wb_wr_data), .wb_rd_data(wb_rd_data), .wb_we(wb_we), .wb_stb(wb_stb),
    .wb_cyc(wb_cyc), .wb_ack(wb_ack), .wb_inta(wb_inta)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // I2C core model: random ack latency, TIP busy for a few polls after each CR write
  always begin
    @(posedge clk); #1;
    if (wb_cyc && wb_stb && !no_ack && rst) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      if (wb_cyc) begin
        if (wb_we) begin
          wlog.push_back(int'({wb_addr, wb_wr_data}));
          if (wb_addr == 3'd4) begin
            cur_nack = (cr_idx == nack_at);
            cr_idx++;
            tip_left = $urandom_range(0, tip_max);
          end
        end else if (wb_addr == 3'd4) begin
          poll_n++;
          if (poll_n == al_at)   wb_rd_data = 8'h20;
          else if (tip_left > 0) begin tip_left--; wb_rd_data = 8'h02; end
          else                   wb_rd_data = cur_nack ? 8'h80 : 8'h00;
        end else begin
          wb_rd_data = 8'hEE;
          if (rx_q.size() > 0) wb_rd_data = rx_q.pop_front();
        end
        wb_ack = 1'b1;
        @(posedge clk); #1;
        wb_ack = 1'b0;
      end
    end
  end

  always @(negedge clk) if (rd_valid) got_rd.push_back(rd_data);

  // expected register-write stream; nk = CR index of the NACKed phase (-1 none)
  task automatic build_exp(input bit init, input bit r, input logic [6:0] sa, input logic [7:0] ma,
                           input int n, input logic [8*MAXB-1:0] d, input int nk);
    int txr[$], cr[$];
    exp_w.delete();
    if (init) begin exp_w.push_back('h0C8); exp_w.push_back('h100); exp_w.push_back('h280); end
    txr.push_back(int'({sa, 1'b0})); cr.push_back('h90);
    txr.push_back(int'(ma));         cr.push_back('h10);
    if (r) begin
      txr.push_back(int'({sa, 1'b1})); cr.push_back('h90);
      for (int i = 0; i < n; i++) begin txr.push_back(-1); cr.push_back(i == n-1 ? 'h68 : 'h20); end
    end else begin
      for (int i = 0; i < n; i++) begin
        txr.push_back(int'(d[8*i +: 8])); cr.push_back(i == n-1 ? 'h50 : 'h10);
      end
    end
    for (int i = 0; i < cr.size(); i++) begin
      if (txr[i] >= 0) exp_w.push_back('h300 | txr[i]);
      exp_w.push_back('h400 | cr[i]);
      if (i == nk) begin exp_w.push_back('h440); break; end
    end
  endtask

  task automatic burst(input bit r, input logic [6:0] sa, input logic [15:0] ma, input logic [LW-1:0] l,
                       input logic [8*MAXB-1:0] d, input int nk, input int al, input bit init,
                       input int exp_err, input string tag);
    int n, cyc;
    n = (l == 0) ? 1 : ((int'(l) > MAXB) ? MAXB : int'(l));
    cyc = 0;
    wlog.delete(); got_rd.delete();
    if (rx_q.size() == 0) for (int i = 0; i < n; i++) rx_q.push_back(8'($urandom));
    exp_rd = rx_q;
    cr_idx = 0; poll_n = 0; nack_at = nk; al_at = al; cur_nack = 1'b0;
    // AL on poll p with no TIP delay lands right after CR index p-1, with no STOP
    if (al >= 0) begin
      build_exp(init, r, sa, ma[7:0], n, d, al - 1);
      void'(exp_w.pop_back());
    end else build_exp(init, r, sa, ma[7:0], n, d, nk);
    @(negedge clk);
    rnw = r; slave_addr = sa; mem_addr = ma; len = l; wr_data = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".busy"}, 32'(busy), 1);
    rnw = ~r; slave_addr = ~sa; mem_addr = ~ma; len = ~l; wr_data = ~d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!done && cyc < 6000) begin @(negedge clk); cyc++; end
    chk({tag, ".done"}, 32'(done), 1);
    chk({tag, ".err"}, 32'(err), 32'(exp_err));
    @(negedge clk);
    chk({tag, ".pulse"}, {30'd0, done, busy}, 0);
    chk({tag, ".nwr"}, wlog.size(), exp_w.size());
    for (int i = 0; i < wlog.size() && i < exp_w.size(); i++)
      chk($sformatf("%s.wr%0d", tag, i), wlog[i], exp_w[i]);
    if (r && nk < 0 && al < 0) begin
      chk({tag, ".nrd"}, got_rd.size(), n);
      for (int i = 0; i < got_rd.size() && i < n; i++)
        chk($sformatf("%s.rd%0d", tag, i), got_rd[i], exp_rd[i]);
    end else chk({tag, ".nrd"}, got_rd.size(), 0);
    rx_q.delete();
  endtask

  initial begin
    int cyc;
    logic [LW-1:0] l;
    bit r;
    int nk;
    repeat (3) @(negedge clk);
    chk("rst.ctl", {busy, done, err, rd_valid}, 0);
    chk("rst.rd_data", rd_data, 0);
    chk("rst.wb", {wb_cyc, wb_stb, wb_we, wb_addr, wb_wr_data}, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    burst(1'b0, 7'h10, 16'h0006, 3, 64'h332211, -1, -1, 1'b1, 0, "wr");
    rx_q.push_back(8'hA5); rx_q.push_back(8'h5A);
    burst(1'b1, 7'h20, 16'h0040, 2, '0, -1, -1, 1'b0, 0, "rd");
    burst(1'b0, 7'h10, 16'h0006, 3, 64'h332211, 1, -1, 1'b0, 1, "nack");
    tip_max = 0;
    burst(1'b0, 7'h10, 16'h0006, 3, 64'h332211, -1, 2, 1'b0, 2, "al");
    tip_max = 2;
    burst(1'b0, 7'h33, 16'h0012, 2, 64'hBEEF, -1, -1, 1'b0, 0, "post_al");
    chk("post_al.first_reg", wlog.size() > 0 ? (wlog[0] >> 8) : -1, 3);

    // ack withheld: fresh init's first access times out
    rst = 1'b0; @(negedge clk); rst = 1'b1; @(negedge clk);
    no_ack = 1'b1; wlog.delete();
    start = 1'b1; @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!done && cyc < 6000) begin @(negedge clk); cyc++; end
    chk("tmo.done", 32'(done), 1);
    chk("tmo.err", 32'(err), 3);
    chk("tmo.cyc", 32'(wb_cyc), 0);
    chk("tmo.lat", 32'(cyc >= 4096 && cyc <= 4110), 1);
    no_ack = 1'b0;
    repeat (3) @(negedge clk);

    // reset in the middle of a read data phase
    wlog.delete(); cr_idx = 0; poll_n = 0; nack_at = -1; al_at = -1;
    rnw = 1'b1; slave_addr = 7'h21; mem_addr = 16'h0010; len = 4;
    start = 1'b1; @(negedge clk); start = 1'b0;
    cyc = 0;
    while (cr_idx < 4 && cyc < 3000) begin @(negedge clk); cyc++; end
    chk("midrst.reach", 32'(cr_idx >= 4), 1);
    rst = 1'b0; @(negedge clk);
    chk("midrst.out", {busy, done, rd_valid, wb_cyc, wb_stb}, 0);
    rst = 1'b1; repeat (4) @(negedge clk);
    burst(1'b1, 7'h21, 16'h0010, 0, '0, -1, -1, 1'b1, 0, "len0");

    for (int it = 0; it < 12; it++) begin
      r  = 1'($urandom_range(0, 1));
      l  = LW'($urandom_range(0, 15));
      nk = -1;
      if ($urandom_range(0, 3) == 0)
        nk = r ? $urandom_range(0, 2)
               : $urandom_range(0, 1 + ((l == 0) ? 1 : ((int'(l) > MAXB) ? MAXB : int'(l))));
      burst(r, 7'($urandom), 16'($urandom), l, {$urandom, $urandom}, nk, -1, 1'b0,
            (nk >= 0) ? 1 : 0, $sformatf("rnd%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
